// File: rtl/hand_bank.sv
// hand_bank: card-hand store for the baccarat datapath.
//   NUM_HANDS hands of MAX_CARDS slots each, shared deal handshake that
//   appends a card to the selected hand, per-hand running baccarat score.
// Ports:
//   slow_clock, resetb         clock, async active-low reset
//   deal_valid/deal_hand/new_card  deal request
//   clear_hand                 per-hand synchronous clear
//   deal_ready                 block is in READY
//   deal_ack / deal_err        1-cycle pulses: deal scored / deal rejected
//   cards_out                  slot s of hand h at [(h*MAX_CARDS+s)*4 +: 4]
//   count_out                  cards of hand h at [h*CNT_W +: CNT_W]
//   score_out                  score of hand h at [h*4 +: 4]
//   full_out                   hand h holds MAX_CARDS cards

// One hand: slots, count and running score. Clear wins over load/update.
module hand_lane #(
  parameter int MAX_CARDS = 3,
  parameter int CNT_W     = $clog2(MAX_CARDS+1)
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   clr,
  input  logic                   load,
  input  logic [3:0]             card,
  input  logic                   upd,
  input  logic [3:0]             val,
  output logic [MAX_CARDS*4-1:0] slots,
  output logic [CNT_W-1:0]       count,
  output logic [3:0]             score,
  output logic                   full
);
  logic [MAX_CARDS-1:0][3:0] slot_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [3:0]                score_q;
  logic [4:0]                sum;
  logic [3:0]                score_nxt;

  // Both operands are 0..9, so one conditional subtract is enough.
  always_comb begin
    sum       = {1'b0, score_q} + {1'b0, val};
    score_nxt = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slot_q  <= '0;
      cnt_q   <= '0;
      score_q <= '0;
    end else if (clr) begin
      slot_q  <= '0;
      cnt_q   <= '0;
      score_q <= '0;
    end else begin
      if (load) begin
        for (int s = 0; s < MAX_CARDS; s++)
          if (cnt_q == CNT_W'(s)) slot_q[s] <= card;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (upd) score_q <= score_nxt;
    end
  end

  assign slots = slot_q;
  assign count = cnt_q;
  assign score = score_q;
  assign full  = (cnt_q == CNT_W'(MAX_CARDS));
endmodule

module hand_bank #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int HSEL_W    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int CNT_W     = $clog2(MAX_CARDS+1)
) (
  input  logic                             slow_clock,
  input  logic                             resetb,
  input  logic                             deal_valid,
  input  logic [HSEL_W-1:0]                deal_hand,
  input  logic [3:0]                       new_card,
  input  logic [NUM_HANDS-1:0]             clear_hand,
  output logic                             deal_ready,
  output logic                             deal_ack,
  output logic                             deal_err,
  output logic [NUM_HANDS*MAX_CARDS*4-1:0] cards_out,
  output logic [NUM_HANDS*CNT_W-1:0]       count_out,
  output logic [NUM_HANDS*4-1:0]           score_out,
  output logic [NUM_HANDS-1:0]             full_out
);
  localparam logic [0:0] READY  = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  logic [0:0]        state;
  logic [HSEL_W-1:0] lat_hand;
  logic [3:0]        lat_val;
  logic              hand_ok, full_sel, clr_sel, lat_clr, card_ok, accept;
  logic [3:0]        value;

  // Hand-indexed lookups done by compare so an out-of-range deal_hand
  // never indexes past the vectors.
  always_comb begin
    hand_ok  = 1'b0;
    full_sel = 1'b0;
    clr_sel  = 1'b0;
    lat_clr  = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HSEL_W'(h)) begin
        hand_ok  = 1'b1;
        full_sel = full_out[h];
        clr_sel  = clear_hand[h];
      end
      if (lat_hand == HSEL_W'(h)) lat_clr = clear_hand[h];
    end
    card_ok = (new_card >= 4'd1) && (new_card <= 4'd13);
    accept  = (state == READY) && deal_valid && hand_ok && !full_sel &&
              card_ok && !clr_sel;
    value   = (new_card <= 4'd9) ? new_card : 4'd0;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state    <= READY;
      lat_hand <= '0;
      lat_val  <= '0;
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
    end else begin
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
      case (state)
        READY: begin
          if (accept) begin
            state    <= UPDATE;
            lat_hand <= deal_hand;
            lat_val  <= value;
          end else if (deal_valid) begin
            deal_err <= 1'b1;
          end
        end
        default: begin
          // A clear of the latched hand drops the score update in the lane.
          state    <= READY;
          deal_ack <= !lat_clr;
        end
      endcase
    end
  end

  assign deal_ready = (state == READY);

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    logic ld, up;
    assign ld = accept && (deal_hand == HSEL_W'(h));
    assign up = (state == UPDATE) && (lat_hand == HSEL_W'(h));
    hand_lane #(.MAX_CARDS(MAX_CARDS), .CNT_W(CNT_W)) u_lane (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .clr        (clear_hand[h]),
      .load       (ld),
      .card       (new_card),
      .upd        (up),
      .val        (lat_val),
      .slots      (cards_out[h*MAX_CARDS*4 +: MAX_CARDS*4]),
      .count      (count_out[h*CNT_W +: CNT_W]),
      .score      (score_out[h*4 +: 4]),
      .full       (full_out[h])
    );
  end
endmodule

// File: tb/tb_hand_bank.sv
module tb_hand_bank;
  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  always #5 slow_clock = ~slow_clock;

  int checks = 0;
  int errors = 0;

  // A: 2 hands x 3 slots
  logic        a_valid = 0, a_hand = 0;
  logic [3:0]  a_card = 0;
  logic [1:0]  a_clear = 0;
  logic        a_ready, a_ack, a_err;
  logic [23:0] a_cards;
  logic [3:0]  a_count;
  logic [7:0]  a_score;
  logic [1:0]  a_full;

  hand_bank #(.NUM_HANDS(2), .MAX_CARDS(3)) dut_a (
    .slow_clock(slow_clock), .resetb(resetb), .deal_valid(a_valid),
    .deal_hand(a_hand), .new_card(a_card), .clear_hand(a_clear),
    .deal_ready(a_ready), .deal_ack(a_ack), .deal_err(a_err),
    .cards_out(a_cards), .count_out(a_count), .score_out(a_score),
    .full_out(a_full));

  // B: single hand
  logic        b_valid = 0, b_hand = 0;
  logic [3:0]  b_card = 0;
  logic [0:0]  b_clear = 0;
  logic        b_ready, b_ack, b_err;
  logic [11:0] b_cards;
  logic [1:0]  b_count;
  logic [3:0]  b_score;
  logic [0:0]  b_full;

  hand_bank #(.NUM_HANDS(1), .MAX_CARDS(3)) dut_b (
    .slow_clock(slow_clock), .resetb(resetb), .deal_valid(b_valid),
    .deal_hand(b_hand), .new_card(b_card), .clear_hand(b_clear),
    .deal_ready(b_ready), .deal_ack(b_ack), .deal_err(b_err),
    .cards_out(b_cards), .count_out(b_count), .score_out(b_score),
    .full_out(b_full));

  // C: 4 hands x 5 slots
  logic        c_valid = 0;
  logic [1:0]  c_hand = 0;
  logic [3:0]  c_card = 0;
  logic [3:0]  c_clear = 0;
  logic        c_ready, c_ack, c_err;
  logic [79:0] c_cards;
  logic [11:0] c_count;
  logic [15:0] c_score;
  logic [3:0]  c_full;

  hand_bank #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_c (
    .slow_clock(slow_clock), .resetb(resetb), .deal_valid(c_valid),
    .deal_hand(c_hand), .new_card(c_card), .clear_hand(c_clear),
    .deal_ready(c_ready), .deal_ack(c_ack), .deal_err(c_err),
    .cards_out(c_cards), .count_out(c_count), .score_out(c_score),
    .full_out(c_full));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    @(negedge slow_clock);
  endtask

  typedef struct {
    logic        v;
    logic        h;
    logic [3:0]  card;
    logic [1:0]  clr;
    logic        rdy, ack, err;
    logic [23:0] cards;
    logic [3:0]  cnt;
    logic [7:0]  score;
    logic [1:0]  full;
  } vec_t;

  vec_t tbl[21];

  // Drive C with one deal, then one idle cycle; returns pulses seen.
  task automatic c_deal(input logic [1:0] h, input logic [3:0] cd,
                        output logic err1, output logic ack2);
    c_valid = 1; c_hand = h; c_card = cd;
    tick();
    err1 = c_err;
    c_valid = 0;
    tick();
    ack2 = c_ack;
  endtask

  initial begin
    logic e, a;
    logic [3:0] c_cards_seq[5];
    logic [3:0] c_score_seq[5];

    //        v  h  card  clr    rdy ack err  cards        cnt      score  full
    tbl[0]  = '{1, 0, 4'd7,  2'b00, 0, 0, 0, 24'h000007, 4'b0001, 8'h00, 2'b00};
    tbl[1]  = '{0, 0, 4'd0,  2'b00, 1, 1, 0, 24'h000007, 4'b0001, 8'h07, 2'b00};
    tbl[2]  = '{1, 1, 4'd9,  2'b00, 0, 0, 0, 24'h009007, 4'b0101, 8'h07, 2'b00};
    tbl[3]  = '{0, 0, 4'd0,  2'b00, 1, 1, 0, 24'h009007, 4'b0101, 8'h97, 2'b00};
    tbl[4]  = '{1, 1, 4'd8,  2'b00, 0, 0, 0, 24'h089007, 4'b1001, 8'h97, 2'b00};
    tbl[5]  = '{0, 0, 4'd0,  2'b00, 1, 1, 0, 24'h089007, 4'b1001, 8'h77, 2'b00};
    tbl[6]  = '{1, 1, 4'd12, 2'b00, 0, 0, 0, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[7]  = '{0, 0, 4'd0,  2'b00, 1, 1, 0, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[8]  = '{1, 1, 4'd5,  2'b00, 1, 0, 1, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[9]  = '{0, 0, 4'd0,  2'b00, 1, 0, 0, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[10] = '{1, 0, 4'd0,  2'b00, 1, 0, 1, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[11] = '{1, 0, 4'd15, 2'b00, 1, 0, 1, 24'hC89007, 4'b1101, 8'h77, 2'b10};
    tbl[12] = '{1, 0, 4'd5,  2'b01, 1, 0, 1, 24'hC89000, 4'b1100, 8'h70, 2'b10};
    tbl[13] = '{1, 0, 4'd3,  2'b00, 0, 0, 0, 24'hC89003, 4'b1101, 8'h70, 2'b10};
    tbl[14] = '{0, 0, 4'd0,  2'b01, 1, 0, 0, 24'hC89000, 4'b1100, 8'h70, 2'b10};
    tbl[15] = '{0, 0, 4'd0,  2'b00, 1, 0, 0, 24'hC89000, 4'b1100, 8'h70, 2'b10};
    tbl[16] = '{1, 0, 4'd2,  2'b00, 0, 0, 0, 24'hC89002, 4'b1101, 8'h70, 2'b10};
    tbl[17] = '{0, 0, 4'd0,  2'b10, 1, 1, 0, 24'h000002, 4'b0001, 8'h02, 2'b00};
    tbl[18] = '{1, 0, 4'd4,  2'b00, 0, 0, 0, 24'h000042, 4'b0010, 8'h02, 2'b00};
    tbl[19] = '{1, 0, 4'd6,  2'b00, 1, 1, 0, 24'h000042, 4'b0010, 8'h06, 2'b00};
    tbl[20] = '{0, 0, 4'd0,  2'b00, 1, 0, 0, 24'h000042, 4'b0010, 8'h06, 2'b00};

    // Reset state
    tick(); tick();
    resetb = 1'b1;
    tick();
    chk("rst_ready", a_ready, 1);
    chk("rst_ack",   a_ack,   0);
    chk("rst_err",   a_err,   0);
    chk("rst_cards", a_cards, 0);
    chk("rst_count", a_count, 0);
    chk("rst_score", a_score, 0);
    chk("rst_full",  a_full,  0);

    // Cycle-by-cycle table on A
    foreach (tbl[i]) begin
      a_valid = tbl[i].v; a_hand = tbl[i].h; a_card = tbl[i].card; a_clear = tbl[i].clr;
      tick();
      chk($sformatf("row%0d_ready", i), a_ready, tbl[i].rdy);
      chk($sformatf("row%0d_ack", i),   a_ack,   tbl[i].ack);
      chk($sformatf("row%0d_err", i),   a_err,   tbl[i].err);
      chk($sformatf("row%0d_cards", i), a_cards, tbl[i].cards);
      chk($sformatf("row%0d_count", i), a_count, tbl[i].cnt);
      chk($sformatf("row%0d_score", i), a_score, tbl[i].score);
      chk($sformatf("row%0d_full", i),  a_full,  tbl[i].full);
    end
    a_valid = 0; a_clear = 0;

    // Reset asserted while in UPDATE: zero immediately, no ack afterwards
    a_valid = 1; a_hand = 1; a_card = 4'd5;
    tick();
    chk("mid_upd_ready", a_ready, 0);
    a_valid = 0;
    resetb = 1'b0;
    #1;
    chk("async_rst_cards", a_cards, 0);
    chk("async_rst_count", a_count, 0);
    chk("async_rst_score", a_score, 0);
    chk("async_rst_ready", a_ready, 1);
    tick();
    resetb = 1'b1;
    tick();
    chk("post_rst_ack0", a_ack, 0);
    tick();
    chk("post_rst_ack1", a_ack, 0);
    chk("post_rst_score", a_score, 0);

    // NUM_HANDS=1: hand index 1 is out of range
    b_valid = 1; b_hand = 1; b_card = 4'd5;
    tick();
    chk("b_bad_hand_err",   b_err,   1);
    chk("b_bad_hand_cards", b_cards, 0);
    chk("b_bad_hand_count", b_count, 0);
    chk("b_bad_hand_ready", b_ready, 1);
    b_hand = 0;
    tick();
    chk("b_good_err",   b_err,   0);
    chk("b_good_cards", b_cards, 12'h005);
    b_valid = 0;
    tick();
    chk("b_good_ack",   b_ack,   1);
    chk("b_good_score", b_score, 4'd5);

    // 4 hands x 5 slots: placement of hand0 and hand2 fields
    c_deal(2'd0, 4'd7, e, a);
    chk("c_h0_err", e, 0);
    chk("c_h0_ack", a, 1);
    chk("c_h0_score", c_score[3:0], 4'd7);
    c_cards_seq = '{4'd9, 4'd8, 4'd12, 4'd3, 4'd6};
    c_score_seq = '{4'd9, 4'd7, 4'd7,  4'd0, 4'd6};
    for (int k = 0; k < 5; k++) begin
      c_deal(2'd2, c_cards_seq[k], e, a);
      chk($sformatf("c_h2_d%0d_err", k),   e, 0);
      chk($sformatf("c_h2_d%0d_ack", k),   a, 1);
      chk($sformatf("c_h2_d%0d_score", k), c_score[11:8], c_score_seq[k]);
    end
    c_deal(2'd2, 4'd1, e, a);
    chk("c_full_err", e, 1);
    chk("c_full_ack", a, 0);
    chk("c_full_ready", c_ready, 1);
    chk("c_cards", c_cards, 80'h0000063C890000000007);
    chk("c_count", c_count, 12'h141);
    chk("c_score", c_score, 16'h0607);
    chk("c_full",  c_full,  4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
